uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with a valid/ready byte output.
// The line is sampled at mid-bit through a 2-flop synchronizer.
// Optional even parity: define UART_RX_PARITY_EN to add one parity bit per frame
// (8E1). Without it, frames are 8N1 and parity_err_o is tied low.
// state_o exposes the FSM state for debug and checker binding.
//
// Output handshake: valid_o=1 means data_o holds an unconsumed byte. A transfer
// happens on a rising edge where valid_o=1 and ready_i=1. data_o only changes
// when valid_o=0 or on a transfer cycle. A byte that completes while an
// untransferred byte is held is dropped, and overrun_o pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic [2:0] state_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          sync1;
  logic          rx_s;
  logic          byte_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign byte_ok = ~par_bad;
`else
  assign byte_ok      = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  assign state_o = state;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  // Receive FSM with registered byte/valid outputs and one-cycle error pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
      par_bad      <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      // A transfer empties the holding register unless a new byte lands below.
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) state <= START;
        end

        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              // Line went back high before mid start bit: glitch, ignore.
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == T_FULL) begin
            timer <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == T_FULL) begin
            timer <= '0;
            // Even parity: data bits plus parity bit hold an even number of ones.
            if ((^shift) != rx_s) begin
              parity_err_o <= 1'b1;
              par_bad      <= 1'b1;
            end
            state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (rx_s) begin
              // Return to IDLE at mid stop bit so the next start edge is caught.
              state <= IDLE;
              if (byte_ok) begin
                if (!valid_o || ready_i) begin
                  data_o  <= shift;
                  valid_o <= 1'b1;
                end else begin
                  overrun_o <= 1'b1;
                end
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        BREAK: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLKS_PER_BIT=16.
// Build with UART_RX_PARITY_EN defined to also exercise the parity frames.
module tb_uart_rx;

  localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + 8 + 10 * CLKS + 1;
`else
  localparam int LAT = 2 + 8 + 9 * CLKS + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic rx_i = 1'b1;
  logic ready_i = 1'b1;
  logic [7:0] data_o;
  logic valid_o, frame_err_o, overrun_o, parity_err_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .rx_i(rx_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .parity_err_o(parity_err_o),
    .state_o(state_o)
  );

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_fall = 0;
  int t_valid = -1;
  int valid_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      valid_cyc++;
      if (t_valid < 0) t_valid = cyc;
    end
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (frame_err_o) ferr_cnt++;
    if (overrun_o) ovr_cnt++;
    if (parity_err_o) perr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    valid_cyc = 0;
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    perr_cnt  = 0;
    t_valid   = -1;
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_errs(input string tag, input int ferr, input int ovr, input int perr);
    chk({tag, "_frame_err"}, ferr_cnt, ferr);
    chk({tag, "_overrun"}, ovr_cnt, ovr);
    chk({tag, "_parity_err"}, perr_cnt, perr);
  endtask

  // ---------------- drivers ----------------
  // All drivers start and end at posedge+1.
  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_state", state_o, 3'd0);
    chk("rst_ferr", frame_err_o, 1'b0);
    chk("rst_ovr", overrun_o, 1'b0);
    chk("rst_perr", parity_err_o, 1'b0);
    idle(3);
    rst_ni = 1'b1;
    idle(5);

    // Plain byte, consumer always ready.
    clr();
    send_byte(8'hA5);
    exp_q.push_back(8'hA5);
    idle(20);
    chk("a5_latency", t_valid - t_fall, LAT);
    chk("a5_valid_cycles", valid_cyc, 1);
    check_errs("a5", 0, 0, 0);
    sb_check("a5");

    // Short low glitch is rejected, then a real byte.
    clr();
    rx_i = 1'b0;
    idle(4);
    rx_i = 1'b1;
    idle(30);
    chk("glitch_state", state_o, 3'd0);
    chk("glitch_valid_cycles", valid_cyc, 0);
    check_errs("glitch", 0, 0, 0);
    send_byte(8'h3C);
    exp_q.push_back(8'h3C);
    idle(20);
    sb_check("glitch_3c");

    // Bad stop bit, line held low (break), then recovery.
    clr();
    send_frame(8'h11, ^8'h11, 1'b0);
    idle(40);
    chk("break_state", state_o, 3'd5);
    rx_i = 1'b1;
    idle(20);
    chk("ferr_valid_cycles", valid_cyc, 0);
    check_errs("ferr", 1, 0, 0);
    chk("ferr_state_idle", state_o, 3'd0);
    sb_check("ferr");
    send_byte(8'h22);
    exp_q.push_back(8'h22);
    idle(20);
    sb_check("after_break_22");

    // Overrun: consumer stalled across two back-to-back bytes.
    clr();
    ready_i = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    idle(20);
    chk("ovr_valid_held", valid_o, 1'b1);
    chk("ovr_data_held", data_o, 8'h01);
    check_errs("ovr", 0, 1, 0);
    ready_i = 1'b1;
    idle(1);
    ready_i = 1'b0;
    chk("ovr_valid_cleared", valid_o, 1'b0);
    exp_q.push_back(8'h01);
    sb_check("ovr");

    // Async reset mid-frame while a byte is held.
    clr();
    send_byte(8'h81);
    idle(10);
    chk("pre_rst_valid", valid_o, 1'b1);
    chk("pre_rst_data", data_o, 8'h81);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("pre_rst_state_data", state_o, 3'd2);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_data", data_o, 8'h00);
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_state", state_o, 3'd0);
    chk("mid_rst_ferr", frame_err_o, 1'b0);
    chk("mid_rst_ovr", overrun_o, 1'b0);
    idle(3);
    rst_ni = 1'b1;
    clr();
    ready_i = 1'b1;
    idle(60);
    chk("post_rst_no_valid", valid_cyc, 0);
    check_errs("post_rst", 0, 0, 0);
    send_byte(8'h5A);
    exp_q.push_back(8'h5A);
    idle(20);
    chk("5a_latency", t_valid - t_fall, LAT);
    chk("5a_valid_cycles", valid_cyc, 1);
    sb_check("post_rst_5a");

`ifdef UART_RX_PARITY_EN
    // Wrong parity drops the byte; right parity delivers it.
    clr();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    chk("par_bad_valid_cycles", valid_cyc, 0);
    check_errs("par_bad", 0, 0, 1);
    sb_check("par_bad");
    clr();
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(8'h07);
    idle(20);
    chk("par_ok_valid_cycles", valid_cyc, 1);
    check_errs("par_ok", 0, 0, 0);
    sb_check("par_ok");
    // Parity and stop both wrong: both pulses.
    clr();
    send_frame(8'h07, 1'b0, 1'b0);
    rx_i = 1'b1;
    idle(20);
    chk("par_stop_valid_cycles", valid_cyc, 0);
    check_errs("par_stop", 1, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
